// File: rtl/key_scan_interface_pkg.sv
// Shared constants and helpers for the matrix keypad scanner.
// Contents:
//   KP_ROWS, KP_COLS, KP_KEYS : keypad geometry (4x4 matrix, 16 keys)
//   KEY_W                     : width of a key code
//   DEF_SCAN_CYCLES           : per-column dwell, 1 ms at 50 MHz
//   DEF_DEBOUNCE_FRAMES       : identical frames needed to accept a change
//   key_index()               : row/column to linear key code (row*KP_COLS+col)
//   col_drive()               : active-low column drive pattern for one column
package key_scan_interface_pkg;

    localparam int KP_ROWS             = 4;
    localparam int KP_COLS             = 4;
    localparam int KP_KEYS             = KP_ROWS * KP_COLS;
    localparam int KEY_W               = 4;
    localparam int DEF_SCAN_CYCLES     = 50_000;
    localparam int DEF_DEBOUNCE_FRAMES = 4;

    function automatic logic [KEY_W-1:0] key_index(input logic [1:0] row,
                                                   input logic [1:0] col);
        return KEY_W'(int'(row) * KP_COLS + int'(col));
    endfunction

    function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] col);
        return ~(KP_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/key_debounce_frame.sv
// Frame-level debouncer and new-press encoder for the keypad scanner.
// A full raw frame arrives with frame_valid_i. The stable key map only follows
// the raw frame once it has been identical for DEBOUNCE_FRAMES frames in a row.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   frame_valid_i : one-cycle strobe, raw_i holds a complete frame
//   raw_i[15:0]   : raw sampled key map, bit[row*4+col] = pressed
//   keys_o[15:0]  : debounced key map
//   pressed_o     : OR of keys_o, registered alongside it
//   event_o       : one-cycle pulse, a new press was accepted this update
//   code_o[3:0]   : lowest-indexed newly pressed key, valid with event_o
module key_debounce_frame
    import key_scan_interface_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_valid_i,
    input  logic [KP_KEYS-1:0] raw_i,
    output logic [KP_KEYS-1:0] keys_o,
    output logic               pressed_o,
    output logic               event_o,
    output logic [KEY_W-1:0]   code_o
);

    // DEBOUNCE_FRAMES is at most 15, so four bits always hold the count.
    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic [KP_KEYS-1:0] prev_q;
    logic [KP_KEYS-1:0] keys_q;
    logic [CNT_W-1:0]   same_cnt_q;
    logic [CNT_W-1:0]   same_cnt_d;
    logic               pressed_q;
    logic               event_q;
    logic [KEY_W-1:0]   code_q;

    logic [KP_KEYS-1:0] new_keys;
    logic               new_any;
    logic [KEY_W-1:0]   new_code;
    logic               update;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        same_cnt_d = '0;
        if (raw_i == prev_q) begin
            same_cnt_d = (same_cnt_q == CNT_MAX) ? same_cnt_q : same_cnt_q + 1'b1;
        end
    end

    assign update   = frame_valid_i && (same_cnt_d == CNT_MAX) && (raw_i != keys_q);
    assign new_keys = raw_i & ~keys_q;

    // Descending scan: the last hit written is the lowest index, which wins.
    always_comb begin
        new_code = '0;
        new_any  = 1'b0;
        for (int i = KP_KEYS - 1; i >= 0; i--) begin
            if (new_keys[i]) begin
                new_code = KEY_W'(i);
                new_any  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            keys_q     <= '0;
            same_cnt_q <= '0;
            pressed_q  <= 1'b0;
            event_q    <= 1'b0;
            code_q     <= '0;
        end else begin
            event_q <= 1'b0;
            if (frame_valid_i) begin
                prev_q     <= raw_i;
                same_cnt_q <= same_cnt_d;
            end
            if (update) begin
                keys_q    <= raw_i;
                pressed_q <= |raw_i;
                event_q   <= new_any;
                code_q    <= new_code;
            end
        end
    end

    assign keys_o    = keys_q;
    assign pressed_o = pressed_q;
    assign event_o   = event_q;
    assign code_o    = code_q;

endmodule

// File: rtl/key_scan_interface.sv
// 4x4 active-low matrix keypad scanner with debounce and a one-entry
// valid/ready key-code output.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   row_i[3:0]    : keypad rows, active low, asynchronous to clk
//   col_o[3:0]    : column drives, active low, one low outside reset
//   rdy_i         : consumer ready; transfer when valid_o & rdy_i
//   key_o[3:0]    : key code row*4+col, held while valid_o
//   valid_o       : key code pending
//   keys_o[15:0]  : debounced key map
//   pressed_o     : any debounced key down
//   ovf_o         : sticky, a press was dropped while a code was pending
module key_scan_interface
    import key_scan_interface_pkg::*;
#(
    parameter int SCAN_CYCLES     = DEF_SCAN_CYCLES,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_ROWS-1:0] row_i,
    output logic [KP_COLS-1:0] col_o,
    input  logic               rdy_i,
    output logic [KEY_W-1:0]   key_o,
    output logic               valid_o,
    output logic [KP_KEYS-1:0] keys_o,
    output logic               pressed_o,
    output logic               ovf_o
);

    localparam int            DW         = $clog2(SCAN_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

    // Row synchronizer
    logic [KP_ROWS-1:0] row_sync1_q;
    logic [KP_ROWS-1:0] row_sync2_q;
    logic [KP_ROWS-1:0] row_act;

    // Scan sequencer
    logic               active_q;
    logic [DW-1:0]      dwell_q;
    logic [1:0]         col_q;
    logic [KP_COLS-1:0] col_o_q;
    logic [KP_KEYS-1:0] raw_q;
    logic               frame_done_q;

    // Handshake
    logic [KEY_W-1:0]   key_q;
    logic               valid_q;
    logic               ovf_q;

    logic               evt;
    logic [KEY_W-1:0]   evt_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sync1_q <= '0;
            row_sync2_q <= '0;
        end else begin
            row_sync1_q <= row_i;
            row_sync2_q <= row_sync1_q;
        end
    end

    assign row_act = ~row_sync2_q;

    // The first cycle out of reset only turns the drive on, so column 0 gets a
    // full SCAN_CYCLES dwell starting at dwell = 0. Sampling in the last dwell
    // cycle leaves time for the pins to settle and pass the synchronizer.
    // NOTE: raw_q is a plain register bank and is reset with everything else;
    // there is no memory macro here that would forbid it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            dwell_q      <= '0;
            col_q        <= '0;
            col_o_q      <= '1;
            raw_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!active_q) begin
                active_q <= 1'b1;
                col_o_q  <= col_drive(2'd0);
            end else if (dwell_q == DWELL_LAST) begin
                dwell_q <= '0;
                col_q   <= col_q + 2'd1;
                col_o_q <= col_drive(col_q + 2'd1);
                for (int r = 0; r < KP_ROWS; r++) begin
                    raw_q[key_index(2'(r), col_q)] <= row_act[r];
                end
                frame_done_q <= (col_q == 2'(KP_COLS - 1));
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
        end
    end

    key_debounce_frame #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_valid_i (frame_done_q),
        .raw_i         (raw_q),
        .keys_o        (keys_o),
        .pressed_o     (pressed_o),
        .event_o       (evt),
        .code_o        (evt_code)
    );

    // One-entry buffer: a new press may replace a code being consumed in the
    // same cycle, otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (evt) begin
            if (!valid_q || rdy_i) begin
                key_q   <= evt_code;
                valid_q <= 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (valid_q && rdy_i) begin
            valid_q <= 1'b0;
        end
    end

    assign col_o   = col_o_q;
    assign key_o   = key_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_key_scan_interface.sv
// Directed bench for key_scan_interface with SCAN_CYCLES=8, DEBOUNCE_FRAMES=3
// (frame = 32 cycles) and an ideal keypad model driving row_i from col_o.
module tb_key_scan_interface;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic        rdy_i;
    logic [3:0]  key_o;
    logic        valid_o;
    logic [15:0] keys_o;
    logic        pressed_o;
    logic        ovf_o;

    logic [15:0] held;
    int          total;
    int          bad;

    key_scan_interface #(
        .SCAN_CYCLES     (8),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_i     (row_i),
        .col_o     (col_o),
        .rdy_i     (rdy_i),
        .key_o     (key_o),
        .valid_o   (valid_o),
        .keys_o    (keys_o),
        .pressed_o (pressed_o),
        .ovf_o     (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_i = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    // Wait until keys_o equals exp, counting valid_o rising edges meanwhile.
    task automatic wait_keys(input logic [15:0] exp, input int budget,
                             output bit ok, output int rises);
        logic pv;
        int   n;
        ok    = 1'b0;
        rises = 0;
        pv    = valid_o;
        n     = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (valid_o && !pv) rises++;
            pv = valid_o;
            if (keys_o == exp) ok = 1'b1;
            n++;
        end
    endtask

    // Count valid_o rising edges over a fixed number of cycles.
    task automatic count_rises(input int cycles, output int rises);
        logic pv;
        rises = 0;
        pv    = valid_o;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_o && !pv) rises++;
            pv = valid_o;
        end
    endtask

    // Return at the first negedge where column 0 has just become driven.
    task automatic sync_col0(output bit ok);
        logic [3:0] pc;
        int         n;
        ok = 1'b0;
        pc = col_o;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge clk);
            if (col_o == 4'b1110 && pc != 4'b1110) ok = 1'b1;
            pc = col_o;
            n++;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        int         col_bad;
        repeat (3) @(negedge clk);
        total++;
        if ({col_o, key_o, valid_o, keys_o, pressed_o, ovf_o} !== {4'b1111, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: col=%b key=%0d valid=%b keys=%h pressed=%b ovf=%b, required col=1111 others 0",
                     col_o, key_o, valid_o, keys_o, pressed_o, ovf_o);
        end
        rst_n = 1'b1;
        col_bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / 8) % 4));
            total++;
            if (col_o !== exp_col || valid_o !== 1'b0 || keys_o !== 16'h0 || ovf_o !== 1'b0) begin
                bad++;
                col_bad++;
                if (col_bad <= 4)
                    $display("FAIL scan_cycle%0d: col=%b valid=%b keys=%h ovf=%b, required col=%b valid=0 keys=0 ovf=0",
                             i, col_o, valid_o, keys_o, ovf_o, exp_col);
            end
        end
    endtask

    task automatic test_clean_press;
        bit ok;
        int rises;
        rdy_i = 1'b1;
        held  = 16'h0040;
        wait_keys(16'h0040, 200, ok, rises);
        total++;
        if (!ok || rises != 0) begin
            bad++;
            $display("FAIL press_keys: reached=%b early_events=%0d keys=%h, required keys=0040 with 0 early events", ok, rises, keys_o);
        end
        total++;
        if (pressed_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL press_latency0: pressed=%b valid=%b, required pressed=1 valid=0", pressed_o, valid_o);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b1 || key_o !== 4'd6) begin
            bad++;
            $display("FAIL press_event: valid=%b key=%0d, required valid=1 key=6", valid_o, key_o);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b0 || key_o !== 4'd6) begin
            bad++;
            $display("FAIL press_consume: valid=%b key=%0d, required valid=0 key=6", valid_o, key_o);
        end
        held = 16'h0000;
        wait_keys(16'h0000, 200, ok, rises);
        total++;
        if (!ok || rises != 0 || pressed_o !== 1'b0) begin
            bad++;
            $display("FAIL press_release: reached=%b events=%0d pressed=%b, required reached with 0 events pressed=0", ok, rises, pressed_o);
        end
    endtask

    task automatic test_bounce;
        bit   ok;
        int   rises;
        int   bounce_rises;
        logic pv;
        rdy_i = 1'b1;
        sync_col0(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bounce_sync: column 0 start not seen, col=%b", col_o);
        end
        bounce_rises = 0;
        pv = valid_o;
        for (int t = 0; t < 150; t++) begin
            if (t % 20 == 0) held[5] = ~held[5];
            @(negedge clk);
            if (valid_o && !pv) bounce_rises++;
            pv = valid_o;
        end
        total++;
        if (bounce_rises != 0 || keys_o !== 16'h0) begin
            bad++;
            $display("FAIL bounce_quiet: events=%0d keys=%h, required 0 events keys=0000", bounce_rises, keys_o);
        end
        held[5] = 1'b1;
        wait_keys(16'h0020, 400, ok, rises);
        total++;
        if (!ok || rises != 0) begin
            bad++;
            $display("FAIL bounce_settle: reached=%b early_events=%0d keys=%h, required keys=0020", ok, rises, keys_o);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b1 || key_o !== 4'd5) begin
            bad++;
            $display("FAIL bounce_event: valid=%b key=%0d, required valid=1 key=5", valid_o, key_o);
        end
        count_rises(100, rises);
        total++;
        if (rises != 0) begin
            bad++;
            $display("FAIL bounce_single: extra events=%0d, required 0", rises);
        end
        held = 16'h0000;
        wait_keys(16'h0000, 200, ok, rises);
        total++;
        if (!ok || rises != 0) begin
            bad++;
            $display("FAIL bounce_release: reached=%b events=%0d keys=%h, required keys=0000 with 0 events", ok, rises, keys_o);
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        int rises;
        rdy_i = 1'b1;
        held  = 16'h0208;
        wait_keys(16'h0208, 300, ok, rises);
        total++;
        if (!ok || rises != 0) begin
            bad++;
            $display("FAIL simul_keys: reached=%b early_events=%0d keys=%h, required keys=0208", ok, rises, keys_o);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b1 || key_o !== 4'd3) begin
            bad++;
            $display("FAIL simul_event: valid=%b key=%0d, required valid=1 key=3", valid_o, key_o);
        end
        count_rises(100, rises);
        total++;
        if (rises != 0) begin
            bad++;
            $display("FAIL simul_single: extra events=%0d, required 0", rises);
        end
        held = 16'h0000;
        wait_keys(16'h0000, 200, ok, rises);
        total++;
        if (!ok || rises != 0) begin
            bad++;
            $display("FAIL simul_release: reached=%b events=%0d, required 0 events", ok, rises);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int rises;
        rdy_i = 1'b0;
        held  = 16'h0002;
        wait_keys(16'h0002, 200, ok, rises);
        @(negedge clk);
        total++;
        if (!ok || valid_o !== 1'b1 || key_o !== 4'd1 || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_first: reached=%b valid=%b key=%0d ovf=%b, required valid=1 key=1 ovf=0", ok, valid_o, key_o, ovf_o);
        end
        held = 16'h4002;
        wait_keys(16'h4002, 200, ok, rises);
        repeat (2) @(negedge clk);
        total++;
        if (!ok || valid_o !== 1'b1 || key_o !== 4'd1 || ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_drop: reached=%b valid=%b key=%0d ovf=%b, required valid=1 key=1 ovf=1", ok, valid_o, key_o, ovf_o);
        end
        rdy_i = 1'b1;
        @(negedge clk);
        total++;
        if (valid_o !== 1'b0 || key_o !== 4'd1) begin
            bad++;
            $display("FAIL bp_drain: valid=%b key=%0d, required valid=0 key=1", valid_o, key_o);
        end
        count_rises(100, rises);
        total++;
        if (rises != 0 || ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_second: events=%0d ovf=%b, required 0 events ovf=1", rises, ovf_o);
        end
        held = 16'h0000;
        wait_keys(16'h0000, 200, ok, rises);
        total++;
        if (!ok || rises != 0) begin
            bad++;
            $display("FAIL bp_release: reached=%b events=%0d, required 0 events", ok, rises);
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        int rises;
        rdy_i = 1'b0;
        held  = 16'h0400;
        wait_keys(16'h0400, 200, ok, rises);
        @(negedge clk);
        total++;
        if (!ok || valid_o !== 1'b1 || key_o !== 4'd10) begin
            bad++;
            $display("FAIL rst_setup: reached=%b valid=%b key=%0d, required valid=1 key=10", ok, valid_o, key_o);
        end
        repeat (5) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({col_o, key_o, valid_o, keys_o, pressed_o, ovf_o} !== {4'b1111, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_async: col=%b key=%0d valid=%b keys=%h pressed=%b ovf=%b, required col=1111 others 0",
                     col_o, key_o, valid_o, keys_o, pressed_o, ovf_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (col_o !== 4'b1110 || valid_o !== 1'b0 || keys_o !== 16'h0) begin
            bad++;
            $display("FAIL rst_restart: col=%b valid=%b keys=%h, required col=1110 valid=0 keys=0000", col_o, valid_o, keys_o);
        end
        held = 16'h0000;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rdy_i = 1'b0;
        held  = 16'h0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
